// File: rtl/mux_rr_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package mux_rr_pkg;

   // Packet-lock state: LIBRE arbitrates every beat, BLOQUEADO holds the grant.
   typedef enum logic {
      LIBRE     = 1'b0,
      BLOQUEADO = 1'b1
   } estado_t;

   // Modulo-n increment; also accepts idx >= n so callers can pass base+offset.
   function automatic int sig_idx(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/mux_rr_stream_arbitro_rr.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from ultimo+1, wrapping modulo CANALES.
module arbitro_rr
   import mux_rr_pkg::*;
#(
   parameter int CANALES = 4,
   localparam int SEL_W  = $clog2(CANALES)
) (
   input  logic [CANALES-1:0] req,
   input  logic [SEL_W-1:0]   ultimo,
   input  logic               habilitar,
   output logic [CANALES-1:0] grant,
   output logic [SEL_W-1:0]   grant_idx,
   output logic               hay_grant
);

   logic [SEL_W-1:0] cand;

   // Circular priority search; the channel just served is checked last.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      hay_grant = 1'b0;
      cand      = '0;
      for (int k = 0; k < CANALES; k++) begin
         cand = SEL_W'(sig_idx(int'(ultimo) + k, CANALES));
         if (habilitar && !hay_grant && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            hay_grant   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_stream.sv
// N:1 round-robin stream multiplexer with a registered output slot.
// Optional packet lock enabled by defining MUX_RR_PAQUETE_EN.
//
//  state     | meaning
//  LIBRE     | arbitrate on every beat
//  BLOQUEADO | grant locked to ultimo until a beat with d_last=1
module mux_rr_stream
   import mux_rr_pkg::*;
#(
   parameter int ANCHO   = 4,
   parameter int CANALES = 4,
   localparam int SEL_W  = $clog2(CANALES)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [CANALES-1:0][ANCHO-1:0] d,
   input  logic [CANALES-1:0]            d_valid,
   output logic [CANALES-1:0]            d_ready,
`ifdef MUX_RR_PAQUETE_EN
   input  logic [CANALES-1:0]            d_last,
   output logic                          q_last,
`endif
   output logic [ANCHO-1:0]              q,
   output logic                          q_valid,
   input  logic                          q_ready,
   output logic [SEL_W-1:0]              q_sel
);

   logic [ANCHO-1:0]   q_q, q_d;
   logic               q_valid_q, q_valid_d;
   logic [SEL_W-1:0]   q_sel_q, q_sel_d;
   logic [SEL_W-1:0]   ultimo_q, ultimo_d;
   estado_t            estado_q, estado_d;
`ifdef MUX_RR_PAQUETE_EN
   logic               q_last_q, q_last_d;
`endif

   logic               carga;
   logic [CANALES-1:0] req_eff;
   logic [CANALES-1:0] lock_mask;
   logic [CANALES-1:0] grant;
   logic [SEL_W-1:0]   grant_idx;
   logic               hay_grant;

   assign carga = !q_valid_q || q_ready;

   // Held in reset, nothing may be offered to the producers.
   arbitro_rr #(.CANALES(CANALES)) u_arbitro (
      .req       (req_eff),
      .ultimo    (ultimo_q),
      .habilitar (carga && rst_n),
      .grant     (grant),
      .grant_idx (grant_idx),
      .hay_grant (hay_grant)
   );

   // State register for the packet-lock FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estado_q <= LIBRE;
      else        estado_q <= estado_d;
   end

   // Next-state: lock on a non-final beat, release on the final one.
   always_comb begin
      estado_d = estado_q;
`ifdef MUX_RR_PAQUETE_EN
      case (estado_q)
         LIBRE:     if (hay_grant && !d_last[grant_idx]) estado_d = BLOQUEADO;
         BLOQUEADO: if (hay_grant &&  d_last[grant_idx]) estado_d = LIBRE;
         default:   estado_d = LIBRE;
      endcase
`endif
   end

   // FSM output: while locked only the channel that owns the packet may request.
   always_comb begin
      lock_mask           = '0;
      lock_mask[ultimo_q] = 1'b1;
      req_eff             = (estado_q == BLOQUEADO) ? (d_valid & lock_mask) : d_valid;
   end

   // Output slot next values: load on transfer, drop valid when drained and idle.
   always_comb begin
      q_d       = q_q;
      q_valid_d = q_valid_q;
      q_sel_d   = q_sel_q;
      ultimo_d  = ultimo_q;
`ifdef MUX_RR_PAQUETE_EN
      q_last_d  = q_last_q;
`endif
      if (hay_grant) begin
         q_d       = d[grant_idx];
         q_sel_d   = grant_idx;
         q_valid_d = 1'b1;
         ultimo_d  = grant_idx;
`ifdef MUX_RR_PAQUETE_EN
         q_last_d  = d_last[grant_idx];
`endif
      end else if (carga) begin
         q_valid_d = 1'b0;
      end
   end

   // Output slot and arbitration pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q       <= '0;
         q_valid_q <= 1'b0;
         q_sel_q   <= '0;
         ultimo_q  <= SEL_W'(CANALES - 1);
`ifdef MUX_RR_PAQUETE_EN
         q_last_q  <= 1'b0;
`endif
      end else begin
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
         q_sel_q   <= q_sel_d;
         ultimo_q  <= ultimo_d;
`ifdef MUX_RR_PAQUETE_EN
         q_last_q  <= q_last_d;
`endif
      end
   end

   assign d_ready = grant;
   assign q       = q_q;
   assign q_valid = q_valid_q;
   assign q_sel   = q_sel_q;
`ifdef MUX_RR_PAQUETE_EN
   assign q_last  = q_last_q;
`endif

endmodule
